// File: rtl/uart_digest_tx_ctrl.sv
// Streams a captured digest to a byte-wide UART transmitter, MSB byte first,
// either as raw bytes or as two lowercase ASCII hex characters per byte.
module uart_digest_tx_ctrl #(
  parameter int NUM_BYTES = 32,
  parameter bit HEX_MODE  = 1'b0,
  parameter int GAP_CLKS  = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [8*NUM_BYTES-1:0]   Digest_in,
  input  logic                     Digest_Valid_in,
  output logic                     Ready_out,
  output logic                     Tx_DV_out,
  output logic [7:0]               Tx_Byte_out,
  input  logic                     Tx_Active_in,
  input  logic                     Tx_Done_in,
  output logic                     Busy_out,
  output logic                     Done_out,
  output logic [6:0]               Char_Cnt_out
);

  localparam int DATA_W = 8 * NUM_BYTES;
  localparam int NCH    = HEX_MODE ? 2 * NUM_BYTES : NUM_BYTES;
  localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  digest_reg, digest_next;
  logic [6:0]         char_cnt_reg, char_cnt_next;
  logic               nib_lo_reg, nib_lo_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               tx_dv_reg, tx_dv_next;
  logic [7:0]         tx_byte_reg, tx_byte_next;
  logic               ready_reg, ready_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  // Current byte always sits in the top 8 bits; hex_char[0] encodes its low nibble.
  logic [7:0] hex_char [2];
  for (genvar gi = 0; gi < 2; gi++) begin : g_hex
    logic [3:0] nib;
    assign nib          = digest_reg[DATA_W-8+4*gi +: 4];
    assign hex_char[gi] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      digest_reg   <= '0;
      char_cnt_reg <= '0;
      nib_lo_reg   <= 1'b0;
      gap_cnt_reg  <= '0;
      tx_dv_reg    <= 1'b0;
      tx_byte_reg  <= '0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      digest_reg   <= digest_next;
      char_cnt_reg <= char_cnt_next;
      nib_lo_reg   <= nib_lo_next;
      gap_cnt_reg  <= gap_cnt_next;
      tx_dv_reg    <= tx_dv_next;
      tx_byte_reg  <= tx_byte_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    digest_next   = digest_reg;
    char_cnt_next = char_cnt_reg;
    nib_lo_next   = nib_lo_reg;
    gap_cnt_next  = gap_cnt_reg;
    tx_dv_next    = 1'b0;
    tx_byte_next  = tx_byte_reg;
    ready_next    = ready_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Digest_Valid_in) begin
          digest_next   = Digest_in;
          char_cnt_next = '0;
          nib_lo_next   = 1'b0;
          ready_next    = 1'b0;
          busy_next     = 1'b1;
          state_next    = REQ;
        end
      end
      REQ: begin
        // A frame may still be running from before a reset; never overlap it.
        if (!Tx_Active_in) begin
          tx_dv_next   = 1'b1;
          tx_byte_next = HEX_MODE ? hex_char[~nib_lo_reg] : digest_reg[DATA_W-1 -: 8];
          if (!HEX_MODE || nib_lo_reg) begin
            digest_next = digest_reg << 8;
          end
          if (HEX_MODE) begin
            nib_lo_next = ~nib_lo_reg;
          end
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (Tx_Done_in) begin
          char_cnt_next = char_cnt_reg + 7'd1;
          if (char_cnt_reg == 7'(NCH - 1)) begin
            done_next  = 1'b1;
            state_next = FINISH;
          end else if (GAP_CLKS > 0) begin
            gap_cnt_next = GAP_W'(GAP_CLKS);
            state_next   = GAP;
          end else begin
            state_next = REQ;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg <= GAP_W'(1)) begin
          state_next = REQ;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      FINISH: begin
        busy_next  = 1'b0;
        ready_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Ready_out    = ready_reg;
  assign Tx_DV_out    = tx_dv_reg;
  assign Tx_Byte_out  = tx_byte_reg;
  assign Busy_out     = busy_reg;
  assign Done_out     = done_reg;
  assign Char_Cnt_out = char_cnt_reg;

endmodule

// File: tb/tb_uart_digest_tx_ctrl.sv
// Three controllers (raw, hex, raw with 20-clock gap) each drive a behavioural
// UART transmitter; decoded serial bytes are scored against expected character queues.
module tb_uart_digest_tx_ctrl;

  localparam int NI = 3;
  localparam int NB = 32;
  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [255:0] dig  [NI];
  logic         val  [NI];
  logic         rdy  [NI];
  logic         dv   [NI];
  logic [7:0]   txb  [NI];
  logic         busy [NI];
  logic         dn   [NI];
  logic [6:0]   cnt  [NI];

  logic [7:0]   exp_mem [NI][512];
  int           wr_ptr  [NI];
  int           errors = 0;
  int           checks = 0;

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nch_of(input int i);
    return (i == 1) ? 2 * NB : NB;
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string digits;
    digits = "0123456789abcdef";
    return digits[n];
  endfunction

  task automatic put(input int i, input logic [7:0] v);
    exp_mem[i][wr_ptr[i] % 512] = v;
    wr_ptr[i]++;
  endtask

  // Reference: bytes in MSB-first order, hex instance expands high nibble first.
  task automatic push_exp(input int i, input logic [255:0] d);
    logic [7:0] b;
    for (int k = 0; k < NB; k++) begin
      b = d[255-8*k -: 8];
      if (i == 1) begin
        put(i, hexc(b[7:4]));
        put(i, hexc(b[3:0]));
      end else begin
        put(i, b);
      end
    end
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2])) begin
      @(negedge CLK);
      n++;
      if (n > 20000) begin
        chk("ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic send_all(input logic [255:0] d);
    wait_all_ready();
    for (int i = 0; i < NI; i++) begin
      push_exp(i, d);
      dig[i] = d;
      val[i] = 1'b1;
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NI; i++) val[i] = 1'b0;
  endtask

  // Valid stays asserted/toggling with a new digest during a transfer; only the
  // value present when Ready_out returns may be taken.
  task automatic hold_two(input int i, input logic [255:0] a, input logic [255:0] b);
    int n = 0;
    dig[i] = a;
    val[i] = 1'b1;
    push_exp(i, a);
    push_exp(i, b);
    @(posedge CLK);
    #1;
    dig[i] = b;
    while (rdy[i] !== 1'b1 && n < 20000) begin
      @(negedge CLK);
      val[i] = 1'($urandom);
      n++;
    end
    chk($sformatf("hold_timeout[%0d]", i), (n < 20000) ? 1 : 0, 1);
    val[i] = 1'b1;
    @(posedge CLK);
    #1;
    val[i] = 1'b0;
    chk($sformatf("second_accept[%0d]", i), {63'd0, rdy[i]}, 0);
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s[%0d]", tag, i),
          {45'd0, rdy[i], dv[i], txb[i], busy[i], dn[i], cnt[i]},
          {45'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 7'd0});
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam bit HX  = (gi == 1);
    localparam int GP  = (gi == 2) ? 20 : 0;
    localparam int NCH = HX ? 2 * NB : NB;

    logic       tx_active = 1'b0;
    logic       tx_done   = 1'b0;
    logic       ser       = 1'b1;
    logic [9:0] frame     = '0;
    int         clkc      = 0;
    int         bitc      = 0;
    int         rd_ptr    = 0;

    uart_digest_tx_ctrl #(.NUM_BYTES(NB), .HEX_MODE(HX), .GAP_CLKS(GP)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .Digest_in       (dig[gi]),
      .Digest_Valid_in (val[gi]),
      .Ready_out       (rdy[gi]),
      .Tx_DV_out       (dv[gi]),
      .Tx_Byte_out     (txb[gi]),
      .Tx_Active_in    (tx_active),
      .Tx_Done_in      (tx_done),
      .Busy_out        (busy[gi]),
      .Done_out        (dn[gi]),
      .Char_Cnt_out    (cnt[gi])
    );

    // Transmitter, 8 clocks per bit; deliberately not reset by RST.
    always @(posedge CLK) begin
      tx_done <= 1'b0;
      if (!tx_active) begin
        if (dv[gi]) begin
          frame     <= {1'b1, txb[gi], 1'b0};
          tx_active <= 1'b1;
          clkc      <= 0;
          bitc      <= 0;
          ser       <= 1'b0;
        end
      end else if (clkc == 7) begin
        clkc <= 0;
        if (bitc == 9) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
          ser       <= 1'b1;
        end else begin
          bitc <= bitc + 1;
          ser  <= frame[bitc+1];
        end
      end else begin
        clkc <= clkc + 1;
      end
    end

    // Serial decoder and scoreboard; frames cut by a reset are discarded.
    initial begin : decode
      logic [7:0] d;
      bit         stale;
      d = '0;
      forever begin
        @(negedge CLK);
        if (RST) rd_ptr = wr_ptr[gi];
        if (ser === 1'b0) begin
          stale = RST;
          for (int s = 0; s < 76; s++) begin
            @(negedge CLK);
            if (RST) begin
              stale  = 1'b1;
              rd_ptr = wr_ptr[gi];
            end
            if (s >= 11 && s <= 67 && ((s - 11) % 8) == 0) d[(s-11)/8] = ser;
          end
          if (!stale) begin
            chk($sformatf("frame_expected[%0d]", gi), (rd_ptr < wr_ptr[gi]) ? 1 : 0, 1);
            chk($sformatf("char[%0d] #%0d", gi, rd_ptr), d, exp_mem[gi][rd_ptr % 512]);
            rd_ptr++;
          end
        end
      end
    end

    // Handshake, pacing and completion checks.
    initial begin : mon
      int     outstanding;
      int     ndone;
      longint cyc;
      longint last_done;
      bit     prev_dn;
      bit     prev_busy;
      outstanding = 0; ndone = 0; cyc = 0; last_done = -1; prev_dn = 0; prev_busy = 0;
      forever begin
        @(negedge CLK);
        cyc++;
        if (RST) begin
          outstanding = 0; ndone = 0; last_done = -1; prev_dn = 0; prev_busy = 0;
        end else begin
          if (busy[gi] && !prev_busy) begin
            ndone     = 0;
            last_done = -1;
          end
          if (dv[gi]) begin
            chk($sformatf("dv_overlap[%0d]", gi), {62'd0, tx_active, outstanding != 0}, 0);
            chk($sformatf("cnt_at_dv[%0d]", gi), cnt[gi], ndone);
            if (last_done >= 0) chk($sformatf("done_to_dv[%0d]", gi), cyc - last_done, GP + 2);
            outstanding = 1;
          end
          if (tx_done && outstanding != 0) begin
            ndone++;
            last_done   = cyc;
            outstanding = 0;
          end
          if (dn[gi]) begin
            chk($sformatf("done_chars[%0d]", gi), ndone, NCH);
            chk($sformatf("done_cnt[%0d]", gi), cnt[gi], NCH);
            chk($sformatf("done_latency[%0d]", gi), cyc - last_done, 1);
            chk($sformatf("done_pulse[%0d]", gi), {63'd0, prev_dn}, 0);
            $display("inst %0d: transfer complete, %0d chars at cycle %0d", gi, ndone, cyc);
          end
          prev_dn   = dn[gi];
          prev_busy = busy[gi];
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < NI; i++) begin
      dig[i] = '0;
      val[i] = 1'b0;
      wr_ptr[i] = 0;
    end
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset("reset_state");
    @(negedge CLK);
    RST = 1'b0;

    send_all(ABC);
    wait_all_ready();
    for (int i = 0; i < NI; i++) chk($sformatf("cnt_held[%0d]", i), cnt[i], nch_of(i));

    fork
      hold_two(0, rand256(), ABC);
      hold_two(1, ABC, rand256());
      hold_two(2, rand256(), rand256());
    join
    wait_all_ready();

    send_all({256{1'b1}});
    send_all('0);
    repeat (2) send_all(rand256());

    // Reset while character 5 of instance 0 is on the wire.
    send_all(rand256());
    n = 0;
    while (cnt[0] != 7'd5 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_char5", (n < 20000) ? 1 : 0, 1);
    repeat (20) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk_reset("async_reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    send_all(256'h1);
    wait_all_ready();
    repeat (200) @(negedge CLK);

    chk("drained[0]", g[0].rd_ptr, wr_ptr[0]);
    chk("drained[1]", g[1].rd_ptr, wr_ptr[1]);
    chk("drained[2]", g[2].rd_ptr, wr_ptr[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
